// File: rtl/word_or_reducer_arbiter_if.sv
// ============================================================================
//  Module      : word_or_reducer_arbiter_if
//  Description : Requester-side and consumer-side signal bundle for the
//                word_or_reducer_arbiter. The master modport is the
//                environment (requesters plus consumer); the slave modport
//                is the arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface word_or_reducer_arbiter_if #(
    parameter int WORD_WIDTH = 36,
    parameter int WORD_COUNT = 16
);
    logic [WORD_COUNT-1:0]            req_valid;
    logic [WORD_WIDTH*WORD_COUNT-1:0] req_data;
    logic [WORD_COUNT-1:0]            req_lock;
    logic [WORD_COUNT-1:0]            req_ready;
    logic                             out_valid;
    logic                             out_ready;
    logic [WORD_WIDTH-1:0]            out_data;
    logic [WORD_COUNT-1:0]            out_grant;

    modport master (
        output req_valid, req_data, req_lock, out_ready,
        input  req_ready, out_valid, out_data, out_grant
    );

    modport slave (
        input  req_valid, req_data, req_lock, out_ready,
        output req_ready, out_valid, out_data, out_grant
    );
endinterface

`default_nettype wire

// File: rtl/word_or_reducer_arbiter.sv
// ============================================================================
//  Module      : word_or_reducer_arbiter
//  Description : Round-robin arbiter sharing one word OR-reducer between
//                WORD_COUNT requesters, with a one-entry valid/ready output
//                register. Optional lock feature: define ARBITER_LOCK_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

// OR-reduces WORD_COUNT packed words into one word.
module word_or_reducer #(
    parameter int WORD_WIDTH = 36,
    parameter int WORD_COUNT = 16
) (
    input  wire  [WORD_WIDTH*WORD_COUNT-1:0] i_words,
    output logic [WORD_WIDTH-1:0]            o_word
);
    // Bitwise OR of every word slice
    always_comb begin
        o_word = '0;
        for (int i = 0; i < WORD_COUNT; i++) begin
            o_word = o_word | i_words[i*WORD_WIDTH +: WORD_WIDTH];
        end
    end
endmodule

module word_or_reducer_arbiter #(
    parameter int WORD_WIDTH = 36,
    parameter int WORD_COUNT = 16
) (
    input wire                          clock,
    input wire                          clear,
    word_or_reducer_arbiter_if.slave    bus
);
    localparam int PTR_W = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
    localparam logic [PTR_W-1:0] c_LAST = PTR_W'(WORD_COUNT - 1);

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    logic [0:0]                      r_state;
    logic [0:0]                      w_state_next;
    logic [PTR_W-1:0]                r_ptr;
    logic [WORD_WIDTH-1:0]           r_data;
    logic [WORD_COUNT-1:0]           r_grant;

    logic                            w_rr_found;
    logic [PTR_W-1:0]                w_rr_winner;
    logic                            w_found;
    logic [PTR_W-1:0]                w_winner;
    logic                            w_load;
    logic                            w_xfer;
    logic                            w_advance;
    logic [WORD_COUNT-1:0]           w_ready;
    logic [WORD_WIDTH*WORD_COUNT-1:0] w_gated;
    logic [WORD_WIDTH-1:0]           w_reduced;

    // Round-robin search: first valid requester starting at the pointer
    always_comb begin
        w_rr_found  = 1'b0;
        w_rr_winner = '0;
        for (int k = 0; k < WORD_COUNT; k++) begin
            if (!w_rr_found && bus.req_valid[(int'(r_ptr) + k) % WORD_COUNT]) begin
                w_rr_found  = 1'b1;
                w_rr_winner = PTR_W'((int'(r_ptr) + k) % WORD_COUNT);
            end
        end
    end

`ifdef ARBITER_LOCK_EN
    logic             r_locked;
    logic [PTR_W-1:0] r_owner;

    // While locked only the owner may win; an idle owner still blocks others
    always_comb begin
        if (r_locked) begin
            w_found  = bus.req_valid[r_owner];
            w_winner = r_owner;
        end else begin
            w_found  = w_rr_found;
            w_winner = w_rr_winner;
        end
    end

    // A locking transfer keeps the pointer parked on the owner
    assign w_advance = w_xfer & ~bus.req_lock[w_winner];

    // Lock ownership tracking
    always_ff @(posedge clock) begin
        if (clear) begin
            r_locked <= 1'b0;
            r_owner  <= '0;
        end else if (w_xfer) begin
            r_locked <= bus.req_lock[w_winner];
            r_owner  <= w_winner;
        end
    end
`else
    logic w_unused_lock;
    assign w_unused_lock = ^bus.req_lock;

    // Pure round-robin selection
    always_comb begin
        w_found  = w_rr_found;
        w_winner = w_rr_winner;
    end

    assign w_advance = w_xfer;
`endif

    // Output register may take a new word when empty or being drained
    assign w_load        = (r_state == S_EMPTY) | bus.out_ready;
    assign w_ready       = (w_found & w_load & ~clear) ? (WORD_COUNT'(1) << w_winner) : '0;
    assign w_xfer        = |w_ready;
    assign bus.req_ready = w_ready;

    generate
        for (genvar i = 0; i < WORD_COUNT; i++) begin : g_gate
            assign w_gated[i*WORD_WIDTH +: WORD_WIDTH] =
                bus.req_data[i*WORD_WIDTH +: WORD_WIDTH] & {WORD_WIDTH{w_ready[i]}};
        end
    endgenerate

    word_or_reducer #(
        .WORD_WIDTH (WORD_WIDTH),
        .WORD_COUNT (WORD_COUNT)
    ) u_reducer (
        .i_words (w_gated),
        .o_word  (w_reduced)
    );

    // State register
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: fill on a transfer, drain when consumed with nothing new
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_EMPTY: if (w_xfer) w_state_next = S_FULL;
            S_FULL:  if (bus.out_ready && !w_xfer) w_state_next = S_EMPTY;
            default: w_state_next = S_EMPTY;
        endcase
    end

    // Output decode
    always_comb begin
        bus.out_valid = (r_state == S_FULL);
        bus.out_data  = r_data;
        bus.out_grant = r_grant;
    end

    // Output word/grant capture; loading with no winner zeroes both
    always_ff @(posedge clock) begin
        if (clear) begin
            r_data  <= '0;
            r_grant <= '0;
        end else if (w_load) begin
            r_data  <= w_reduced;
            r_grant <= w_ready;
        end
    end

    // Priority pointer moves to one past the winner on each transfer
    always_ff @(posedge clock) begin
        if (clear) begin
            r_ptr <= '0;
        end else if (w_advance) begin
            r_ptr <= (w_winner == c_LAST) ? '0 : w_winner + PTR_W'(1);
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_word_or_reducer_arbiter.sv
// ============================================================================
//  Module      : tb_word_or_reducer_arbiter
//  Description : Self-checking bench for word_or_reducer_arbiter with a
//                behavioural round-robin reference model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_word_or_reducer_arbiter;
    localparam int W = 36;
    localparam int N = 16;

    logic clk;
    logic clear;

    word_or_reducer_arbiter_if #(.WORD_WIDTH(W), .WORD_COUNT(N)) bus ();

    word_or_reducer_arbiter #(.WORD_WIDTH(W), .WORD_COUNT(N)) dut (
        .clock (clk),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int             m_ptr;
    bit             m_valid;
    logic [W-1:0]   m_data;
    logic [N-1:0]   m_grant;
    bit             m_locked;
    int             m_owner;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] word_of(input int i);
        return bus.req_data[i*W +: W];
    endfunction

    // Index of the requester accepted this cycle, or -1
    function automatic int model_winner();
        if (clear) return -1;
        if (m_valid && !bus.out_ready) return -1;
        if (m_locked) return bus.req_valid[m_owner] ? m_owner : -1;
        for (int k = 0; k < N; k++) begin
            if (bus.req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_update(input int w);
        if (clear) begin
            m_ptr = 0; m_valid = 0; m_data = '0; m_grant = '0; m_locked = 0; m_owner = 0;
        end else if (!m_valid || bus.out_ready) begin
            if (w >= 0) begin
                m_valid = 1;
                m_data  = word_of(w);
                m_grant = N'(1) << w;
`ifdef ARBITER_LOCK_EN
                if (bus.req_lock[w]) begin
                    m_locked = 1; m_owner = w;
                end else begin
                    m_locked = 0; m_ptr = (w + 1) % N;
                end
`else
                m_ptr = (w + 1) % N;
`endif
            end else begin
                m_valid = 0; m_data = '0; m_grant = '0;
            end
        end
    endtask

    // One clock: check combinational ready, advance model, check registers
    task automatic cycle();
        int w;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        w = model_winner();
        exp_rdy = (w >= 0) ? (N'(1) << w) : '0;
        check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
        model_update(w);
        @(posedge clk);
        #1;
        check("out_valid", 64'(bus.out_valid), 64'(m_valid));
        check("out_data",  64'(bus.out_data),  64'(m_data));
        check("out_grant", 64'(bus.out_grant), 64'(m_grant));
    endtask

    task automatic set_words_index();
        for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = W'(i);
    endtask

    logic [W-1:0] held_data;
    logic [N-1:0] held_grant;

    initial begin
        m_ptr = 0; m_valid = 0; m_data = '0; m_grant = '0; m_locked = 0; m_owner = 0;
        clear = 1'b1;
        bus.req_valid = '1;
        bus.req_data  = '0;
        bus.req_lock  = '0;
        bus.out_ready = 1'b1;

        // Reset / idle: ready must stay low while clear is high
        repeat (2) cycle();
        clear = 1'b0;
        bus.req_valid = '0;
        repeat (3) cycle();

        // Single requester 5
        bus.req_valid = N'(1) << 5;
        bus.req_data[5*W +: W] = 36'h9_ABCD_0123;
        cycle();
        check("single_data",  64'(bus.out_data),  64'h9_ABCD_0123);
        check("single_grant", 64'(bus.out_grant), 64'h20);
        bus.req_valid = '0;
        cycle();

        // Fairness and wrap from a fresh pointer
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        set_words_index();
        bus.req_valid = '1;
        for (int k = 0; k < N + 2; k++) begin
            cycle();
            check("rr_grant", 64'(bus.out_grant), 64'(N'(1) << (k % N)));
            check("rr_data",  64'(bus.out_data),  64'(k % N));
        end

        // Backpressure with requesters 2 and 3
        bus.req_valid = N'(12);
        cycle();
        held_data  = bus.out_data;
        held_grant = bus.out_grant;
        bus.out_ready = 1'b0;
        repeat (3) begin
            cycle();
            check("bp_data",  64'(bus.out_data),  64'(held_data));
            check("bp_grant", 64'(bus.out_grant), 64'(held_grant));
        end
        bus.out_ready = 1'b1;
        repeat (2) cycle();

        // Clear while FULL, then requester 0 must win first
        bus.req_valid = '1;
        bus.out_ready = 1'b0;
        cycle();
        clear = 1'b1;
        cycle();
        check("clr_valid", 64'(bus.out_valid), 64'd0);
        clear = 1'b0;
        bus.out_ready = 1'b1;
        cycle();
        check("clr_first", 64'(bus.out_grant), 64'd1);

`ifdef ARBITER_LOCK_EN
        // Requester 4 holds a lock for three words, then 7 follows
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        bus.req_valid = N'(1) << 3;
        cycle();
        bus.req_valid = (N'(1) << 1) | (N'(1) << 4) | (N'(1) << 7);
        for (int k = 0; k < 3; k++) begin
            bus.req_lock = (k < 2) ? (N'(1) << 4) : '0;
            cycle();
            check("lock_grant", 64'(bus.out_grant), 64'h10);
        end
        bus.req_lock = '0;
        cycle();
        check("lock_after", 64'(bus.out_grant), 64'h80);
`endif

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            bus.req_valid = N'($urandom);
            for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = W'({$urandom, $urandom});
            bus.req_lock  = N'($urandom) & N'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            clear = ($urandom_range(0, 40) == 0);
            cycle();
        end
        clear = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/word_or_reducer_arbiter.md
# word_or_reducer_arbiter

Round-robin arbiter that shares one Word_OR_Reducer datapath between WORD_COUNT requesters. Each cycle it picks one valid requester, zeroes all other words, OR-reduces the result to a single word and captures it in a one-entry output register with a valid/ready handshake. It sits in front of any shared consumer, such as a write port or bus, that is fed by several word sources.

## Interface
- WORD_WIDTH, 36, bits per word
- WORD_COUNT, 16, number of requesters (>= 1)
- clock  input  1  sole clock, all state changes on rising edge
- clear  input  1  synchronous, active-high reset
- req_valid  input  WORD_COUNT  per-requester word-available flag
- req_data  input  WORD_WIDTH*WORD_COUNT  packed words, requester i at bits [i*WORD_WIDTH +: WORD_WIDTH]
- req_lock  input  WORD_COUNT  per-requester lock request (used only with ARBITER_LOCK_EN)
- req_ready  output  WORD_COUNT  one-hot (or zero) accept strobe, combinational
- out_valid  output  1  output register holds a word
- out_ready  input  1  consumer accepts the output word this cycle
- out_data  output  WORD_WIDTH  granted word
- out_grant  output  WORD_COUNT  one-hot source ID of out_data

## Operation
- One clock; reset is synchronous and active-high, on `clear`.
- Define load = ~out_valid | out_ready.
- Priority pointer ptr (clog2(WORD_COUNT) bits, 0 when WORD_COUNT=1): search order is ptr, ptr+1, ..., wrapping modulo WORD_COUNT.
- winner = first i in search order with req_valid[i].
- req_ready[winner] = load & ~clear; all other req_ready bits are 0.
- Transfer from requester i happens in any cycle where req_valid[i] & req_ready[i].
- Datapath:
  - each word is ANDed with its req_ready bit;
  - the gated words are OR-reduced by an instantiated Word_OR_Reducer;
  - exactly one or zero words are non-zero, so out_data equals the winner's word exactly.
- Effective states:
  - EMPTY (out_valid=0):
    - any req_valid -> FULL;
    - otherwise stay EMPTY with out_data=0 and out_grant=0.
  - FULL (out_valid=1):
    - out_ready with a winner -> reload, stay FULL;
    - out_ready without a winner -> EMPTY, out_data=0, out_grant=0;
    - ~out_ready -> hold out_data, out_grant and out_valid unchanged.
- On a transfer from winner w:
  - out_data <= word w;
  - out_grant <= 1<<w;
  - out_valid <= 1;
  - ptr <= (w+1) mod WORD_COUNT.
- ptr changes only on a transfer.
- Requesters must hold req_valid and req_data stable until accepted. A requester that drops req_valid before acceptance is simply not considered.

## Timing
- Reset values: out_valid=0, out_data=0, out_grant=0, ptr=0, lock state cleared. req_ready=0 while clear is high.
- clear mid-operation discards any held word in the same edge. No transfer is accepted in that cycle.
- Latency: accepted request -> out_valid/out_data visible on the next cycle.
- Throughput: one word per cycle when out_ready is held high.
- out_ready and req_valid propagate combinationally to req_ready. out_* are registered outputs.
- Simultaneous out_ready and new winner: the old word leaves and the new word loads on the same edge, with no bubble.
- Wrap-around: a win by requester WORD_COUNT-1 sets ptr to 0.
- Fairness: with all requesters continuously valid, each is granted exactly once per WORD_COUNT transfers.

## Configuration
- Macro: ARBITER_LOCK_EN.
- Defined:
  - a transfer from w with req_lock[w]=1 sets owner=w, locked=1;
  - while locked, only the owner is eligible, even if its req_valid is 0 (in that case no transfer happens) and ptr does not advance;
  - lock releases on an owner transfer with req_lock[w]=0, and ptr then advances to w+1;
  - clear releases the lock.
- Undefined: req_lock is ignored, no lock state exists, and pure round-robin applies.

## Test plan
- Reset/idle:
  - stimulus: hold clear 2 cycles, then all req_valid=0;
  - required: out_valid=0, out_data=0, out_grant=0 and req_ready=0 throughout.
- Single requester:
  - stimulus: req_valid[5]=1 with word 36'h9_ABCD_0123, out_ready=1;
  - required: req_ready=1<<5 in the same cycle, next cycle out_data=36'h9_ABCD_0123 and out_grant=1<<5.
- Round-robin fairness and wrap:
  - stimulus: all 16 req_valid held high with word i = i, out_ready=1;
  - required: grants arrive in order 0,1,...,15,0,1 with no bubbles.
- Backpressure:
  - stimulus: out_ready=0 for 3 cycles while FULL with requesters 2 and 3 valid;
  - required: out_data and out_grant stay stable and req_ready=0. When out_ready rises, the new word loads in the same cycle.
- Reset mid-burst:
  - stimulus: clear asserted while FULL;
  - required: next cycle out_valid=0 and ptr=0, so requester 0 wins first afterwards.
- Lock (ARBITER_LOCK_EN):
  - stimulus: requester 4 sends 3 words with req_lock=1,1,0 while requesters 1 and 7 are valid;
  - required: grants 4,4,4, then 7.
